// File: rtl/logic_unit_tester_pkg.sv
// logic_unit_tester_pkg: shared FSM states, op encodings and vector layout for the logic unit tester
package logic_unit_tester_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;
  localparam int NUM_VECTORS = 16;
  localparam int S1_POS = 3;
  localparam int S0_POS = 2;
  localparam int A_POS  = 1;
  localparam int B_POS  = 0;
endpackage

// File: rtl/logic_unit_tester_model.sv
// logic_unit_model: combinational expected output of the 4-function logic unit (i_s1,i_s0,i_a,i_b -> o_exp)
module logic_unit_model
  import logic_unit_tester_pkg::*;
(
  input  logic i_s1,
  input  logic i_s0,
  input  logic i_a,
  input  logic i_b,
  output logic o_exp
);
  logic [1:0] w_op;
  assign w_op = {i_s1, i_s0};
  always_comb o_exp = (w_op == OP_AND) ? (i_a & i_b) :
                      (w_op == OP_OR)  ? (i_a | i_b) :
                      (w_op == OP_XOR) ? (i_a ^ i_b) : ~i_a;
endmodule

// File: rtl/logic_unit_tester.sv
// logic_unit_tester: sweeps all 16 {s1,s0,a,b} vectors into a logic unit and reports errors (start -> busy/done/pass/err_count/first_fail_*)
module logic_unit_tester
  import logic_unit_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_VECTORS   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_o,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_s1,
  output logic       drv_s0,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);
  state_t     r_state;
  logic [3:0] r_idx;
  logic [3:0] r_wait;
  logic [3:0] w_nxt;
  logic       w_exp;
  logic       w_miss;
  assign w_nxt  = r_idx + 4'd1;
  assign w_miss = dut_o != w_exp;
  logic_unit_model u_model (
    .i_s1 (drv_s1),
    .i_s0 (drv_s0),
    .i_a  (drv_a),
    .i_b  (drv_b),
    .o_exp(w_exp)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state          <= IDLE;
      r_idx            <= 4'd0;
      r_wait           <= 4'd0;
      drv_a            <= 1'b0;
      drv_b            <= 1'b0;
      drv_s1           <= 1'b0;
      drv_s0           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 5'd0;
      first_fail_vec   <= 4'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE:
          if (start) begin
            err_count        <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
            r_idx            <= 4'd0;
            r_wait           <= 4'd0;
            busy             <= 1'b1;
            r_state          <= APPLY;
          end
        APPLY:
          if (r_wait == 4'(SETTLE_CYCLES - 1)) r_state <= SAMPLE;
          else r_wait <= r_wait + 4'd1;
        SAMPLE: begin
          if (w_miss) begin
            err_count <= err_count + 5'd1;
            if (!first_fail_valid) begin
              first_fail_vec   <= r_idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (r_idx == 4'(NUM_VECTORS - 1)) r_state <= DONE;
          else begin
            r_idx   <= w_nxt;
            r_wait  <= 4'd0;
            drv_s1  <= w_nxt[S1_POS];
            drv_s0  <= w_nxt[S0_POS];
            drv_a   <= w_nxt[A_POS];
            drv_b   <= w_nxt[B_POS];
            r_state <= APPLY;
          end
        end
        DONE: begin
          done    <= 1'b1;
          pass    <= err_count == 5'd0;
          busy    <= 1'b0;
          drv_s1  <= 1'b0;
          drv_s0  <= 1'b0;
          drv_a   <= 1'b0;
          drv_b   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_logic_unit_tester.sv
// tb_logic_unit_tester: random fault tables driven through two testers (settle 1 and 3) against a cycle-schedule model
module tb_logic_unit_tester;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_w = 2'b00;
  logic [1:0] dut_o_w, a_w, b_w, s1_w, s0_w, busy_w, done_w, pass_w, ffvalid_w;
  logic [4:0] err_w [2];
  logic [3:0] ffv_w [2];
  logic [15:0] tab_cur [2];
  int tests = 0;
  int fails = 0;
  bit          m_busy [2];
  bit          m_ran  [2];
  bit          m_done [2];
  bit          m_pass [2];
  int          m_c    [2];
  logic [15:0] m_tab  [2];
  always #5 clk = ~clk;
  assign dut_o_w[0] = tab_cur[0][{s1_w[0], s0_w[0], a_w[0], b_w[0]}];
  assign dut_o_w[1] = tab_cur[1][{s1_w[1], s0_w[1], a_w[1], b_w[1]}];
  logic_unit_tester #(.SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .dut_o(dut_o_w[0]),
    .drv_a(a_w[0]), .drv_b(b_w[0]), .drv_s1(s1_w[0]), .drv_s0(s0_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .first_fail_vec(ffv_w[0]), .first_fail_valid(ffvalid_w[0])
  );
  logic_unit_tester #(.SETTLE_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .dut_o(dut_o_w[1]),
    .drv_a(a_w[1]), .drv_b(b_w[1]), .drv_s1(s1_w[1]), .drv_s0(s0_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .first_fail_vec(ffv_w[1]), .first_fail_valid(ffvalid_w[1])
  );
  function automatic bit ref_o(input int v);
    logic [3:0] x;
    x = v[3:0];
    case (x[3:2])
      2'd0:    return x[1] & x[0];
      2'd1:    return x[1] | x[0];
      2'd2:    return x[1] ^ x[0];
      default: return !x[1];
    endcase
  endfunction
  function automatic int errs(input logic [15:0] t, input int n);
    int e = 0;
    for (int v = 0; v < n; v++) if (t[v] != ref_o(v)) e++;
    return e;
  endfunction
  function automatic int first_f(input logic [15:0] t, input int n);
    for (int v = 0; v < n; v++) if (t[v] != ref_o(v)) return v;
    return -1;
  endfunction
  function automatic logic [15:0] good_tab();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = ref_o(v);
    return t;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // A run lasts 16*(S+1)+1 cycles after the accept edge; done appears on the cycle after that.
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 0; m_ran[i] <= 0; m_done[i] <= 0; m_pass[i] <= 0; m_c[i] <= 0; m_tab[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 0;
        if (!m_busy[i]) begin
          if (start_w[i]) begin
            m_busy[i] <= 1; m_c[i] <= 0; m_ran[i] <= 1; m_tab[i] <= tab_cur[i];
          end
        end else if (m_c[i] + 1 == 16 * ((i == 1 ? 3 : 1) + 1) + 1) begin
          m_busy[i] <= 0; m_done[i] <= 1; m_pass[i] <= errs(m_tab[i], 16) == 0;
        end else m_c[i] <= m_c[i] + 1;
      end
    end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      int s, k, drv, smp, ff;
      s = (i == 1) ? 3 : 1;
      if (m_busy[i]) begin
        k   = m_c[i] / (s + 1);
        drv = k > 15 ? 15 : k;
        smp = k > 16 ? 16 : k;
      end else begin
        drv = 0;
        smp = m_ran[i] ? 16 : 0;
      end
      ff = first_f(m_tab[i], smp);
      chk($sformatf("busy%0d", i), busy_w[i], m_busy[i]);
      chk($sformatf("done%0d", i), done_w[i], m_done[i]);
      chk($sformatf("pass%0d", i), pass_w[i], m_pass[i]);
      chk($sformatf("drv%0d", i), {s1_w[i], s0_w[i], a_w[i], b_w[i]}, drv);
      chk($sformatf("err%0d", i), err_w[i], errs(m_tab[i], smp));
      chk($sformatf("ffvalid%0d", i), ffvalid_w[i], ff >= 0);
      chk($sformatf("ffvec%0d", i), ffv_w[i], ff >= 0 ? ff : 0);
    end
  task automatic run(input int i, input logic [15:0] tab, input bit hold, output int lat);
    tab_cur[i] = tab;
    @(negedge clk);
    start_w[i] = 1'b1;
    @(negedge clk);
    if (!hold) start_w[i] = 1'b0;
    lat = 0;
    while (!done_w[i] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!done_w[i]) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int lat;
    logic [15:0] g;
    g = good_tab();
    tab_cur[0] = g;
    tab_cur[1] = g;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(0, g, 0, lat);
    chk("lat_s1", lat, 33);
    chk("good_pass", pass_w[0], 1);
    chk("good_err", err_w[0], 0);
    chk("good_ffvalid", ffvalid_w[0], 0);
    @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy_w[0], 0);
    chk("rst_pass", pass_w[0], 0);
    chk("rst_drv", {s1_w[0], s0_w[0], a_w[0], b_w[0]}, 0);
    chk("rst_err", err_w[0], 0);
    chk("rst_ffvalid", ffvalid_w[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(0, g, 0, lat);
    chk("rerun_pass", pass_w[0], 1);
    run(0, 16'h0000, 0, lat);
    chk("tie0_err", err_w[0], 8);
    chk("tie0_ffv", ffv_w[0], 4'b0011);
    chk("tie0_pass", pass_w[0], 0);
    run(0, 16'hFFFF, 0, lat);
    chk("tie1_err", err_w[0], 8);
    chk("tie1_ffv", ffv_w[0], 4'b0000);
    run(0, g ^ 16'h0F00, 0, lat);
    chk("xnor_err", err_w[0], 4);
    chk("xnor_ffv", ffv_w[0], 4'b1000);
    for (int r = 0; r < 6; r++)
      run(0, r[0] ? 16'($urandom) : g ^ (16'd1 << $urandom_range(15)), 0, lat);
    run(1, 16'($urandom), 1, lat);
    chk("lat_s3", lat, 65);
    @(negedge clk);
    chk("restart_busy", busy_w[1], 1);
    lat = 1;
    tab_cur[1] = tab_cur[1];
    while (!done_w[1] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("lat_s3_held", lat, 66);
    start_w[1] = 1'b0;
    run(1, g, 0, lat);
    chk("s3_pass", pass_w[1], 1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
